universal_binary_counter: RTL and testbench

//  Free-running, parameterizable binary counter with terminal-count flags.

---
 rtl/universal_binary_counter.sv | 73 +++++++
 tb/tb_universal_binary_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/universal_binary_counter.sv
// ---------------------------------------------------------------------------
// universal_binary_counter
//   Free-running modulo-MOD_VAL binary counter (up or down, fixed STEP) with
//   terminal-count decodes. Used as a timebase / sequence source.
//
// Parameters
//   N        counter width in bits (2..32)
//   MOD_VAL  modulus, count spans 0..MOD_VAL-1 (2..2**N)
//   DIR      0 = count up, 1 = count down
//   STEP     amount added/subtracted per clock (1..MOD_VAL-1)
//
// Ports
//   clk       in   1  system clock, rising-edge active
//   rst       in   1  asynchronous reset, active-high (forces out = 0)
//   out       out  N  current count value (registered)
//   max_tick  out  1  high while out == MOD_VAL-1 (decode of out)
//   min_tick  out  1  high while out == 0 (decode of out)
// ---------------------------------------------------------------------------
module universal_binary_counter #(
    parameter int unsigned     N       = 16,
    parameter longint unsigned MOD_VAL = 64'd1 << N,
    parameter int unsigned     DIR     = 0,
    parameter int unsigned     STEP    = 1
) (
    input  logic         clk,
    input  logic         rst,
    output logic [N-1:0] out,
    output logic         max_tick,
    output logic         min_tick
);

    // One spare bit so the sum/difference never loses its carry/borrow.
    localparam int unsigned  W      = N + 1;
    localparam logic [W-1:0] C_MOD  = W'(MOD_VAL);
    localparam logic [W-1:0] C_STEP = W'(STEP);
    localparam logic [N-1:0] C_MAX  = N'(MOD_VAL - 64'd1);

    logic [N-1:0] r_out;
    logic [W-1:0] w_sum;
    logic [W-1:0] w_diff;
    logic         w_wrap_up;
    logic         w_wrap_dn;
    logic [N-1:0] w_next;

    // Next count: step, then fold back into 0..MOD_VAL-1.
    always_comb begin
        w_sum     = {1'b0, r_out} + C_STEP;
        w_diff    = {1'b0, r_out} - C_STEP;
        w_wrap_up = (w_sum >= C_MOD);
        // out and STEP are both below 2**N, so a borrow always sets bit N.
        w_wrap_dn = w_diff[N];
        w_next    = '0;
        if (DIR == 0) begin
            w_next = w_wrap_up ? N'(w_sum - C_MOD) : N'(w_sum);
        end else begin
            w_next = w_wrap_dn ? N'(w_diff + C_MOD) : N'(w_diff);
        end
    end

    // Count register; reset takes effect immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else begin
            r_out <= w_next;
        end
    end

    assign out      = r_out;
    assign max_tick = (r_out == C_MAX);
    assign min_tick = (r_out == '0);

endmodule

// File: tb/tb_universal_binary_counter.sv
// ---------------------------------------------------------------------------
// tb_universal_binary_counter
//   Directed bench for universal_binary_counter: default 16-bit up counter,
//   a modulo-10 4-bit up counter and a 4-bit down counter with STEP=3.
// ---------------------------------------------------------------------------
module tb_universal_binary_counter;

    logic        clk;
    logic        rst0;
    logic        rst1;
    logic        rst2;

    logic [15:0] out0;
    logic        max0;
    logic        min0;
    logic [3:0]  out1;
    logic        max1;
    logic        min1;
    logic [3:0]  out2;
    logic        max2;
    logic        min2;

    int checks;
    int errors;

    universal_binary_counter u_def (
        .clk      (clk),
        .rst      (rst0),
        .out      (out0),
        .max_tick (max0),
        .min_tick (min0)
    );

    universal_binary_counter #(
        .N       (4),
        .MOD_VAL (10)
    ) u_m10 (
        .clk      (clk),
        .rst      (rst1),
        .out      (out1),
        .max_tick (max1),
        .min_tick (min1)
    );

    universal_binary_counter #(
        .N       (4),
        .MOD_VAL (16),
        .DIR     (1),
        .STEP    (3)
    ) u_dn (
        .clk      (clk),
        .rst      (rst2),
        .out      (out2),
        .max_tick (max2),
        .min_tick (min2)
    );

    // 20 ns period, rising edges at 5, 25, 45, ... ns.
    initial begin
        clk = 1'b0;
        #5;
        forever begin
            clk = 1'b1;
            #10;
            clk = 1'b0;
            #10;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 2 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    logic [3:0] seq10 [12];
    logic [3:0] seqdn [16];

    initial begin
        checks = 0;
        errors = 0;
        rst0   = 1'b0;
        rst1   = 1'b0;
        rst2   = 1'b0;
        seq10  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
        seqdn  = '{4'd13, 4'd10, 4'd7, 4'd4, 4'd1, 4'd14, 4'd11, 4'd8,
                   4'd5, 4'd2, 4'd15, 4'd12, 4'd9, 4'd6, 4'd3, 4'd0};

        // Reset at 100 ns, checked before the next clock edge (105 ns).
        #100;
        rst0 = 1'b1;
        rst1 = 1'b1;
        rst2 = 1'b1;
        #2;
        check("rst_out0", 32'(out0), 32'h0);
        check("rst_min0", 32'(min0), 32'h1);
        check("rst_max0", 32'(max0), 32'h0);
        check("rst_out1", 32'(out1), 32'h0);
        check("rst_out2", 32'(out2), 32'h0);
        #8;
        rst0 = 1'b0;

        // First edge after release steps straight to 1.
        tick(1);
        check("cnt1", 32'(out0), 32'h1);
        check("cnt1_min", 32'(min0), 32'h0);
        tick(1);
        check("cnt2", 32'(out0), 32'h2);
        tick(1);
        check("cnt3", 32'(out0), 32'h3);

        // Approach and cross the wrap point.
        tick(65531);
        check("cnt_fffe", 32'(out0), 32'hFFFE);
        check("cnt_fffe_max", 32'(max0), 32'h0);
        tick(1);
        check("cnt_ffff", 32'(out0), 32'hFFFF);
        check("cnt_ffff_max", 32'(max0), 32'h1);
        check("cnt_ffff_min", 32'(min0), 32'h0);
        tick(1);
        check("wrap_out", 32'(out0), 32'h0);
        check("wrap_min", 32'(min0), 32'h1);
        check("wrap_max", 32'(max0), 32'h0);

        // Reset held across many edges keeps the other counters at zero.
        check("held_out1", 32'(out1), 32'h0);
        check("held_out2", 32'(out2), 32'h0);

        // Asynchronous reset between edges at 0x1234.
        tick(16'h1234);
        check("pre_async", 32'(out0), 32'h1234);
        #5;
        rst0 = 1'b1;
        #1;
        check("async_out", 32'(out0), 32'h0);
        check("async_min", 32'(min0), 32'h1);
        #1;
        rst0 = 1'b0;
        tick(1);
        check("resume1", 32'(out0), 32'h1);
        tick(1);
        check("resume2", 32'(out0), 32'h2);

        // Modulo-10 up counter.
        rst1 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check($sformatf("m10_out[%0d]", i), 32'(out1), 32'(seq10[i]));
            check($sformatf("m10_max[%0d]", i), 32'(max1), (seq10[i] == 4'd9) ? 32'h1 : 32'h0);
            check($sformatf("m10_min[%0d]", i), 32'(min1), (seq10[i] == 4'd0) ? 32'h1 : 32'h0);
        end

        // Down counter, STEP=3, modulo 16.
        rst2 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            check($sformatf("dn_out[%0d]", i), 32'(out2), 32'(seqdn[i]));
            check($sformatf("dn_min[%0d]", i), 32'(min2), (seqdn[i] == 4'd0) ? 32'h1 : 32'h0);
            check($sformatf("dn_max[%0d]", i), 32'(max2), (seqdn[i] == 4'd15) ? 32'h1 : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
